vga_scan_ctrl: RTL and testbench
================================

Name: vga_scan_ctrl

Overview:
- Display-side consumer of the SRAM controller's VRAM scan port.
- Generates 640x480@60Hz VGA timing from the 25 MHz pixel clock and drives vram_scan_addr one frame-linear word per pixel.
- Takes the returned 16-bit RGB565 word on vram_scan_data and drives 12-bit RGB plus HS/VS to the board DAC, with sync delayed to match fetch latency.

Parameters:
- VRAM_BASE, 20'h80000, SRAM word address of pixel (0,0).
- FETCH_LAT, 2, clk_25mhz cycles from vram_scan_addr change to matching vram_scan_data valid; legal 1..4.
- H_VIS/H_FP/H_SYNC/H_BP, 640/16/96/48, horizontal timing in pixels.
- V_VIS/V_FP/V_SYNC/V_BP, 480/10/2/33, vertical timing in lines.

Ports:
- clk_25mhz  in  1  pixel clock.
- rst_n  in  1  asynchronous active-low reset.
- vram_scan_addr  out  20  SRAM word address of the pixel being fetched.
- vram_scan_data  in  16  RGB565 pixel returned FETCH_LAT cycles after its address.
- vga_r / vga_g / vga_b  out  4 each  pixel colour.
- vga_hs / vga_vs  out  1 each  sync, active low.
- frame_start  out  1  one-cycle pulse at h_cnt=0, v_cnt=0.
- in_vblank  out  1  high while v_cnt >= V_VIS, for software page-flip polling.

Behaviour:
- Counters:
  - h_cnt 0..799 wraps every line.
  - v_cnt 0..524 increments when h_cnt wraps 799->0; v_cnt wraps 524->0.
  - H_TOT = 800, V_TOT = 525, both derived from the parameters.
- Fetch stage (cycle of h_cnt/v_cnt):
  - fetch_active = (h_cnt < H_VIS) && (v_cnt < V_VIS).
  - Address is an incremental counter, with no multiplier:
    - Reset value is VRAM_BASE.
    - Increments by 1 on every fetch_active cycle.
    - Reloads VRAM_BASE when v_cnt wraps to 0.
  - During blanking the counter holds. vram_scan_addr is a registered copy of it.
- Delay line: FETCH_LAT-deep shift register carries fetch_active, hs_raw and vs_raw.
  - hs_raw low for h_cnt in [H_VIS+H_FP, H_VIS+H_FP+H_SYNC-1] = [656,751].
  - vs_raw low for v_cnt in [490,491].
- Output stage: registered.
  - When the delayed active bit is 1: vga_r = data[15:12], vga_g = data[10:7], vga_b = data[4:1].
  - Otherwise RGB = 0.
  - vga_hs/vga_vs are the delayed raw syncs.
  - Net effect: the first pixel appears on the pins FETCH_LAT+1 cycles after h_cnt=0, and syncs shift by the same amount.
- frame_start and in_vblank are derived combinationally from the undelayed counters, then registered (1-cycle latency).
- Reset (asynchronous, any time including mid-line):
  - h_cnt = 0, v_cnt = 0, address = VRAM_BASE.
  - Delay line cleared to active=0, hs=1, vs=1.
  - RGB = 0, vga_hs = 1, vga_vs = 1, frame_start = 0, in_vblank = 0.
  - First frame after release starts at h_cnt=0, v_cnt=0.
- No handshake with the SRAM controller: the scan port is owned every other 50 MHz phase, so a read is assumed every pixel cycle. vram_scan_data is sampled unconditionally.
- Boundaries:
  - Last visible pixel: address VRAM_BASE+307199 = 20'hCAFFF.
  - Address never exceeds this value.
  - At v_cnt wrap the address reloads in the same cycle h_cnt returns to 0, so pixel (0,0) is fetched from VRAM_BASE.

Optional Feature:
- VGA_SCAN_DOUBLE_EN defined: 320x240 framebuffer shown pixel- and line-doubled.
  - Address advances on odd h_cnt only.
  - At the end of each even visible line the address rewinds by 320 words.
  - Last address VRAM_BASE+76799.
- Not defined: 640x480 native behaviour as above.
- Timing, latency and sync are identical either way.

Test Plan:
- Reset release, FETCH_LAT=2:
  - vram_scan_addr=20'h80000.
  - vga_hs first falls 656+2+1 cycles after release, low for 96 cycles.
  - Line period 800 cycles.
- Full frame:
  - vga_vs low for exactly 1600 cycles starting at line 490.
  - frame_start pulses every 420000 cycles.
  - in_vblank high for 45 lines.
- Data model returning low 16 bits of the address FETCH_LAT later:
  - Pixel (0,0) outputs data 16'h0000.
  - Pixel (639,0) outputs data 16'h027F.
  - Pixel (0,1) outputs 16'h0280.
- Blanking: data model driving 16'hFFFF constantly -> RGB is 0 at h_cnt 640..799 (delayed) and throughout lines 480..524; address holds at 20'hCB000 during vblank. That is the post-increment value after the last fetch of 20'hCAFFF.
- Reset asserted mid-line (h_cnt=300, v_cnt=100):
  - Outputs go to reset values immediately, without a clock edge.
  - After release, addr=20'h80000 and timing restarts from (0,0).
- VGA_SCAN_DOUBLE_EN:
  - Lines 0 and 1 both fetch 20'h80000..20'h8013F, each address twice.
  - Line 2 starts at 20'h80140.

Source files
------------

// File: rtl/vga_scan_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : vga_scan_ctrl
//  Purpose  : 640x480@60Hz VGA scan-out engine. Walks the frame in raster
//             order, drives one frame-linear VRAM word address per pixel
//             clock, and turns the RGB565 word returned FETCH_LAT cycles later
//             into 12-bit RGB. HS/VS go through the same delay so they stay
//             aligned with the pixels.
//  Options  : VGA_SCAN_DOUBLE_EN - when defined, shows a 320x240 framebuffer
//             pixel- and line-doubled. Timing, latency and sync are unchanged.
//  Ports    : clk_25mhz      in   1   pixel clock
//             rst_n          in   1   asynchronous active-low reset
//             vram_scan_addr out  20  SRAM word address being fetched
//             vram_scan_data in   16  RGB565 word, FETCH_LAT cycles after addr
//             vga_r/g/b      out  4   pixel colour (0 during blanking)
//             vga_hs/vga_vs  out  1   syncs, active low
//             frame_start    out  1   one-cycle pulse at h_cnt=0, v_cnt=0
//             in_vblank      out  1   high while v_cnt >= V_VIS
//  Revision : 1.0  initial release
// ============================================================================
module vga_scan_ctrl #(
   parameter logic [19:0] VRAM_BASE = 20'h80000,
   parameter int          FETCH_LAT = 2,      // legal 1..4
   parameter int          H_VIS     = 640,
   parameter int          H_FP      = 16,
   parameter int          H_SYNC    = 96,
   parameter int          H_BP      = 48,
   parameter int          V_VIS     = 480,
   parameter int          V_FP      = 10,
   parameter int          V_SYNC    = 2,
   parameter int          V_BP      = 33
) (
   input  logic        clk_25mhz,
   input  logic        rst_n,
   output logic [19:0] vram_scan_addr,
   input  logic [15:0] vram_scan_data,
   output logic [3:0]  vga_r,
   output logic [3:0]  vga_g,
   output logic [3:0]  vga_b,
   output logic        vga_hs,
   output logic        vga_vs,
   output logic        frame_start,
   output logic        in_vblank
);

   localparam int H_TOT = H_VIS + H_FP + H_SYNC + H_BP;
   localparam int V_TOT = V_VIS + V_FP + V_SYNC + V_BP;

   localparam logic [9:0]  c_H_LAST     = 10'(H_TOT - 1);
   localparam logic [9:0]  c_V_LAST     = 10'(V_TOT - 1);
   localparam logic [9:0]  c_H_VIS      = 10'(H_VIS);
   localparam logic [9:0]  c_V_VIS      = 10'(V_VIS);
   localparam logic [9:0]  c_H_VIS_LAST = 10'(H_VIS - 1);
   localparam logic [9:0]  c_HS_BEG     = 10'(H_VIS + H_FP);
   localparam logic [9:0]  c_HS_END     = 10'(H_VIS + H_FP + H_SYNC - 1);
   localparam logic [9:0]  c_VS_BEG     = 10'(V_VIS + V_FP);
   localparam logic [9:0]  c_VS_END     = 10'(V_VIS + V_FP + V_SYNC - 1);
`ifdef VGA_SCAN_DOUBLE_EN
   // Net step at the end of an even line: +1 for the last pixel pair, then
   // back one 320-word source row so the next line repeats it.
   localparam logic [19:0] c_REWIND     = 20'(H_VIS / 2 - 1);
`endif

   // Raster counters and fetch address
   logic [9:0]  h_cnt_q, h_cnt_d;
   logic [9:0]  v_cnt_q, v_cnt_d;
   logic [19:0] addr_q,  addr_d;

   // Latency-matching delay line (index FETCH_LAT-1 is the oldest)
   logic [FETCH_LAT-1:0] act_dly_q;
   logic [FETCH_LAT-1:0] hs_dly_q;
   logic [FETCH_LAT-1:0] vs_dly_q;

   // Registered outputs
   logic [3:0] vga_r_q, vga_g_q, vga_b_q;
   logic       vga_hs_q, vga_vs_q, frame_start_q, in_vblank_q;

   // Fetch-stage decode from the undelayed counters
   logic fetch_active, h_wrap, v_wrap, hs_raw, vs_raw;

   assign fetch_active = (h_cnt_q < c_H_VIS) && (v_cnt_q < c_V_VIS);
   assign h_wrap       = (h_cnt_q == c_H_LAST);
   assign v_wrap       = (v_cnt_q == c_V_LAST);
   assign hs_raw       = !((h_cnt_q >= c_HS_BEG) && (h_cnt_q <= c_HS_END));
   assign vs_raw       = !((v_cnt_q >= c_VS_BEG) && (v_cnt_q <= c_VS_END));

   always_comb begin
      h_cnt_d = h_cnt_q + 10'd1;
      v_cnt_d = v_cnt_q;
      addr_d  = addr_q;

      if (h_wrap) begin
         h_cnt_d = '0;
         v_cnt_d = v_wrap ? '0 : v_cnt_q + 10'd1;
      end

      // The wrap cycle is always blanking, so the reload never competes with
      // an increment; pixel (0,0) of the next frame sees VRAM_BASE.
      if (h_wrap && v_wrap) begin
         addr_d = VRAM_BASE;
      end
`ifdef VGA_SCAN_DOUBLE_EN
      else if (fetch_active && h_cnt_q[0]) begin
         if ((h_cnt_q == c_H_VIS_LAST) && !v_cnt_q[0]) begin
            addr_d = addr_q - c_REWIND;
         end else begin
            addr_d = addr_q + 20'd1;
         end
      end
`else
      else if (fetch_active) begin
         addr_d = addr_q + 20'd1;
      end
`endif
   end

   always_ff @(posedge clk_25mhz or negedge rst_n) begin
      if (!rst_n) begin
         h_cnt_q       <= '0;
         v_cnt_q       <= '0;
         addr_q        <= VRAM_BASE;
         act_dly_q     <= '0;
         hs_dly_q      <= '1;
         vs_dly_q      <= '1;
         vga_r_q       <= '0;
         vga_g_q       <= '0;
         vga_b_q       <= '0;
         vga_hs_q      <= 1'b1;
         vga_vs_q      <= 1'b1;
         frame_start_q <= 1'b0;
         in_vblank_q   <= 1'b0;
      end else begin
         h_cnt_q <= h_cnt_d;
         v_cnt_q <= v_cnt_d;
         addr_q  <= addr_d;

         act_dly_q[0] <= fetch_active;
         hs_dly_q[0]  <= hs_raw;
         vs_dly_q[0]  <= vs_raw;
         for (int i = 1; i < FETCH_LAT; i++) begin
            act_dly_q[i] <= act_dly_q[i-1];
            hs_dly_q[i]  <= hs_dly_q[i-1];
            vs_dly_q[i]  <= vs_dly_q[i-1];
         end

         // Data is sampled unconditionally; the delayed active bit gates it.
         if (act_dly_q[FETCH_LAT-1]) begin
            vga_r_q <= vram_scan_data[15:12];
            vga_g_q <= vram_scan_data[10:7];
            vga_b_q <= vram_scan_data[4:1];
         end else begin
            vga_r_q <= '0;
            vga_g_q <= '0;
            vga_b_q <= '0;
         end
         vga_hs_q <= hs_dly_q[FETCH_LAT-1];
         vga_vs_q <= vs_dly_q[FETCH_LAT-1];

         frame_start_q <= (h_cnt_q == '0) && (v_cnt_q == '0);
         in_vblank_q   <= (v_cnt_q >= c_V_VIS);
      end
   end

   assign vram_scan_addr = addr_q;
   assign vga_r          = vga_r_q;
   assign vga_g          = vga_g_q;
   assign vga_b          = vga_b_q;
   assign vga_hs         = vga_hs_q;
   assign vga_vs         = vga_vs_q;
   assign frame_start    = frame_start_q;
   assign in_vblank      = in_vblank_q;

endmodule
`default_nettype wire

// File: tb/tb_vga_scan_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_vga_scan_ctrl
//  Purpose  : Scoreboard bench for vga_scan_ctrl. Instance A uses the full
//             640x480 timing with a VRAM model returning the low 16 address
//             bits FETCH_LAT=2 cycles later. Instance B uses a shrunk raster
//             (16x8 visible, 24x14 total, FETCH_LAT=3) so whole frames, vblank
//             and a mid-frame asynchronous reset fit in a short run.
//             Expected values are pushed per (phase, cycle); a negedge
//             monitor pops and compares them.
//  Revision : 1.0  initial release
// ============================================================================
module tb_vga_scan_ctrl;

   logic clk;
   logic rst_n_a, rst_n_b;

   logic [19:0] addr_a, addr_b;
   logic [15:0] data_a, data_b;
   logic [3:0]  r_a, g_a, b_a, r_b, g_b, b_b;
   logic        hs_a, vs_a, fs_a, vb_a;
   logic        hs_b, vs_b, fs_b, vb_b;

   vga_scan_ctrl u_a (
      .clk_25mhz     (clk),
      .rst_n         (rst_n_a),
      .vram_scan_addr(addr_a),
      .vram_scan_data(data_a),
      .vga_r         (r_a),
      .vga_g         (g_a),
      .vga_b         (b_a),
      .vga_hs        (hs_a),
      .vga_vs        (vs_a),
      .frame_start   (fs_a),
      .in_vblank     (vb_a)
   );

   vga_scan_ctrl #(
      .VRAM_BASE(20'h01000), .FETCH_LAT(3),
      .H_VIS(16), .H_FP(2), .H_SYNC(4), .H_BP(2),
      .V_VIS(8),  .V_FP(2), .V_SYNC(2), .V_BP(2)
   ) u_b (
      .clk_25mhz     (clk),
      .rst_n         (rst_n_b),
      .vram_scan_addr(addr_b),
      .vram_scan_data(data_b),
      .vga_r         (r_b),
      .vga_g         (g_b),
      .vga_b         (b_b),
      .vga_hs        (hs_b),
      .vga_vs        (vs_b),
      .frame_start   (fs_b),
      .in_vblank     (vb_b)
   );

   // Signal selectors for scoreboard entries
   localparam int S_ADDR_A = 0, S_RGB_A = 1, S_HS_A = 2, S_VS_A = 3, S_FS_A = 4, S_VB_A = 5;
   localparam int S_ADDR_B = 6, S_RGB_B = 7, S_HS_B = 8, S_VS_B = 9, S_FS_B = 10, S_VB_B = 11;

   // Mode-dependent hand-computed values
`ifdef VGA_SCAN_DOUBLE_EN
   localparam int A_RGB5 = 'h000, A_RGB258 = 'h00F, A_RGB642 = 'h02F, A_RGB803 = 'h000, A_RGB1123 = 'h010;
   localparam int A_AD639 = 'h8013F, A_AD640 = 'h80000, A_AD800 = 'h80000, A_AD802 = 'h80001;
   localparam int A_AD1439 = 'h8013F, A_AD1600 = 'h80140;
   localparam int B_AD15 = 'h01007, B_AD16 = 'h01000, B_AD183 = 'h0101F, B_AD184 = 'h01020;
   localparam int B_AD337 = 'h01000, B_AD1 = 'h01000;
`else
   localparam int A_RGB5 = 'h001, A_RGB258 = 'h01F, A_RGB642 = 'h04F, A_RGB803 = 'h050, A_RGB1123 = 'h070;
   localparam int A_AD639 = 'h8027F, A_AD640 = 'h80280, A_AD800 = 'h80280, A_AD802 = 'h80282;
   localparam int A_AD1439 = 'h804FF, A_AD1600 = 'h80500;
   localparam int B_AD15 = 'h0100F, B_AD16 = 'h01010, B_AD183 = 'h0107F, B_AD184 = 'h01080;
   localparam int B_AD337 = 'h01001, B_AD1 = 'h01001;
`endif

   typedef struct {
      int ph;
      int cyc;
      int sig;
      int val;
   } exp_t;

   exp_t sb[$];
   int   checks   = 0;
   int   errors   = 0;
   int   phase    = 0;
   int   base     = 0;
   int   edge_cnt = 0;

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial forever begin
      @(posedge clk);
      edge_cnt++;
   end

   // VRAM model for A: data in cycle k is the low half of the address of
   // cycle k-2. Updated mid-cycle, ahead of the sampling edge.
   logic [19:0] hist_a [0:2];
   initial begin
      data_a = 16'h0000;
      data_b = 16'hFFFF;
      for (int i = 0; i < 3; i++) hist_a[i] = 20'h0;
      forever begin
         @(negedge clk);
         hist_a[2] = hist_a[1];
         hist_a[1] = hist_a[0];
         hist_a[0] = addr_a;
         data_a    = hist_a[2][15:0];
      end
   end

   task automatic sb_push(input int ph, input int cyc, input int sig, input int val);
      exp_t e;
      e.ph  = ph;
      e.cyc = cyc;
      e.sig = sig;
      e.val = val;
      sb.push_back(e);
   endtask

   function automatic int actual(input int sig);
      case (sig)
         S_ADDR_A: return int'(addr_a);
         S_RGB_A:  return int'({r_a, g_a, b_a});
         S_HS_A:   return int'(hs_a);
         S_VS_A:   return int'(vs_a);
         S_FS_A:   return int'(fs_a);
         S_VB_A:   return int'(vb_a);
         S_ADDR_B: return int'(addr_b);
         S_RGB_B:  return int'({r_b, g_b, b_b});
         S_HS_B:   return int'(hs_b);
         S_VS_B:   return int'(vs_b);
         S_FS_B:   return int'(fs_b);
         default:  return int'(vb_b);
      endcase
   endfunction

   function automatic string sname(input int sig);
      case (sig)
         S_ADDR_A: return "addr_a";
         S_RGB_A:  return "rgb_a";
         S_HS_A:   return "hs_a";
         S_VS_A:   return "vs_a";
         S_FS_A:   return "frame_start_a";
         S_VB_A:   return "in_vblank_a";
         S_ADDR_B: return "addr_b";
         S_RGB_B:  return "rgb_b";
         S_HS_B:   return "hs_b";
         S_VS_B:   return "vs_b";
         S_FS_B:   return "frame_start_b";
         default:  return "in_vblank_b";
      endcase
   endfunction

   // Monitor: compare every entry scheduled for this phase and cycle
   initial forever begin
      @(negedge clk);
      if (phase != 0) begin
         int k;
         int act;
         k = edge_cnt - base;
         for (int i = sb.size() - 1; i >= 0; i--) begin
            if (sb[i].ph == phase && sb[i].cyc == k) begin
               act = actual(sb[i].sig);
               checks++;
               if (act != sb[i].val) begin
                  errors++;
                  $display("FAIL %s ph%0d k=%0d: got 'h%0h, expected 'h%0h",
                           sname(sb[i].sig), phase, k, act, sb[i].val);
               end
               sb.delete(i);
            end
         end
      end
   end

   // Entries never reached by the monitor count as failures
   task automatic flush(input int ph);
      for (int i = sb.size() - 1; i >= 0; i--) begin
         if (sb[i].ph == ph) begin
            checks++;
            errors++;
            $display("FAIL %s ph%0d k=%0d: never checked, expected 'h%0h",
                     sname(sb[i].sig), ph, sb[i].cyc, sb[i].val);
            sb.delete(i);
         end
      end
   endtask

   initial begin
      rst_n_a = 1'b0;
      rst_n_b = 1'b0;

      // ---------------- Phase 1: instance A, full 640x480 timing ----------
      sb_push(1, 0, S_ADDR_A, 'h80000);
      sb_push(1, 0, S_RGB_A, 0);
      sb_push(1, 0, S_HS_A, 1);
      sb_push(1, 0, S_VS_A, 1);
      sb_push(1, 0, S_FS_A, 0);
      sb_push(1, 0, S_VB_A, 0);
      sb_push(1, 1, S_FS_A, 1);
      sb_push(1, 2, S_FS_A, 0);
      sb_push(1, 801, S_FS_A, 0);
      sb_push(1, 2, S_RGB_A, 0);
      sb_push(1, 3, S_RGB_A, 0);            // pixel (0,0), data 0000
      sb_push(1, 5, S_RGB_A, A_RGB5);
      sb_push(1, 258, S_RGB_A, A_RGB258);
      sb_push(1, 642, S_RGB_A, A_RGB642);   // pixel (639,0)
      sb_push(1, 643, S_RGB_A, 0);          // h=640 blank
      sb_push(1, 802, S_RGB_A, 0);          // h=799 blank
      sb_push(1, 803, S_RGB_A, A_RGB803);   // pixel (0,1)
      sb_push(1, 1123, S_RGB_A, A_RGB1123);
      sb_push(1, 639, S_ADDR_A, A_AD639);
      sb_push(1, 640, S_ADDR_A, A_AD640);
      sb_push(1, 800, S_ADDR_A, A_AD800);
      sb_push(1, 802, S_ADDR_A, A_AD802);
      sb_push(1, 1439, S_ADDR_A, A_AD1439);
      sb_push(1, 1600, S_ADDR_A, A_AD1600);
      sb_push(1, 658, S_HS_A, 1);
      sb_push(1, 659, S_HS_A, 0);           // 656+2+1
      sb_push(1, 754, S_HS_A, 0);
      sb_push(1, 755, S_HS_A, 1);           // 96 cycles low
      sb_push(1, 1458, S_HS_A, 1);
      sb_push(1, 1459, S_HS_A, 0);          // line period 800
      sb_push(1, 1600, S_VS_A, 1);
      sb_push(1, 1600, S_VB_A, 0);

      repeat (3) @(posedge clk);
      #2;
      base    = edge_cnt;
      phase   = 1;
      rst_n_a = 1'b1;
      repeat (1610) @(posedge clk);
      #2;
      flush(1);

      // ---------------- Phase 2: instance B, shrunk raster ----------------
      sb_push(2, 0, S_ADDR_B, 'h01000);
      sb_push(2, 0, S_RGB_B, 0);
      sb_push(2, 0, S_HS_B, 1);
      sb_push(2, 0, S_VS_B, 1);
      sb_push(2, 0, S_FS_B, 0);
      sb_push(2, 0, S_VB_B, 0);
      sb_push(2, 1, S_FS_B, 1);
      sb_push(2, 2, S_FS_B, 0);
      sb_push(2, 336, S_FS_B, 0);
      sb_push(2, 337, S_FS_B, 1);           // frame period 336
      sb_push(2, 3, S_RGB_B, 0);
      sb_push(2, 4, S_RGB_B, 'hFFF);        // first pixel at FETCH_LAT+1
      sb_push(2, 19, S_RGB_B, 'hFFF);
      sb_push(2, 20, S_RGB_B, 0);
      sb_push(2, 27, S_RGB_B, 0);
      sb_push(2, 28, S_RGB_B, 'hFFF);
      sb_push(2, 196, S_RGB_B, 0);          // vblank line 8
      sb_push(2, 250, S_RGB_B, 0);
      sb_push(2, 15, S_ADDR_B, B_AD15);
      sb_push(2, 16, S_ADDR_B, B_AD16);
      sb_push(2, 24, S_ADDR_B, B_AD16);
      sb_push(2, 183, S_ADDR_B, B_AD183);   // last visible pixel
      sb_push(2, 184, S_ADDR_B, B_AD184);
      sb_push(2, 300, S_ADDR_B, B_AD184);   // held through vblank
      sb_push(2, 336, S_ADDR_B, 'h01000);   // reload at frame wrap
      sb_push(2, 337, S_ADDR_B, B_AD337);
      sb_push(2, 21, S_HS_B, 1);
      sb_push(2, 22, S_HS_B, 0);
      sb_push(2, 25, S_HS_B, 0);
      sb_push(2, 26, S_HS_B, 1);
      sb_push(2, 243, S_VS_B, 1);
      sb_push(2, 244, S_VS_B, 0);
      sb_push(2, 291, S_VS_B, 0);
      sb_push(2, 292, S_VS_B, 1);
      sb_push(2, 192, S_VB_B, 0);
      sb_push(2, 193, S_VB_B, 1);
      sb_push(2, 336, S_VB_B, 1);
      sb_push(2, 337, S_VB_B, 0);
      sb_push(2, 585, S_VS_B, 0);           // mid vsync, frame 2
      sb_push(2, 585, S_VB_B, 1);
      sb_push(2, 585, S_ADDR_B, B_AD184);
      // reset asserted 1 ns after the edge that starts cycle 586
      sb_push(2, 586, S_ADDR_B, 'h01000);
      sb_push(2, 586, S_RGB_B, 0);
      sb_push(2, 586, S_HS_B, 1);
      sb_push(2, 586, S_VS_B, 1);
      sb_push(2, 586, S_FS_B, 0);
      sb_push(2, 586, S_VB_B, 0);

      base    = edge_cnt;
      phase   = 2;
      rst_n_b = 1'b1;
      repeat (586) @(posedge clk);
      #1;
      rst_n_b = 1'b0;
      repeat (3) @(posedge clk);
      #2;
      flush(2);

      // ---------------- Phase 3: B restarts from (0,0) --------------------
      sb_push(3, 0, S_ADDR_B, 'h01000);
      sb_push(3, 0, S_HS_B, 1);
      sb_push(3, 0, S_VS_B, 1);
      sb_push(3, 0, S_VB_B, 0);
      sb_push(3, 1, S_FS_B, 1);
      sb_push(3, 1, S_ADDR_B, B_AD1);
      sb_push(3, 2, S_FS_B, 0);
      sb_push(3, 4, S_RGB_B, 'hFFF);
      sb_push(3, 16, S_ADDR_B, B_AD16);
      sb_push(3, 22, S_HS_B, 0);

      base    = edge_cnt;
      phase   = 3;
      rst_n_b = 1'b1;
      repeat (30) @(posedge clk);
      #2;
      flush(3);
      phase = 0;

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
